seg_scan_ctrl: RTL and testbench

Time-multiplexing scan controller for the shared 4-digit seven-segment display. It takes the four per-digit segment encodings produced by the game controller (dig1..dig4, active-low, 7'b1111111 = blank) and drives the shared cathode bus and the per-digit anode enables. Digit values are latched once per frame so the display never tears. Per-digit blinking and global enable are supported. It sits between the game-control logic and the board pins.

---
 rtl/seg_scan_if.sv | 29 ++
 rtl/seg_scan_ctrl.sv | 183 ++++++++++++++++++
 tb/tb_seg_scan_ctrl.sv | 277 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/seg_scan_if.sv
// seg_scan_if: bundle between the game-control logic and the display scanner.
//   enable      : 1 = display on, 0 = forced blank (timing keeps running)
//   dig1..dig4  : active-low segment codes, dig1 = leftmost digit
//   blink_mask  : bit 3 = dig1 ... bit 0 = dig4, 1 = digit blinks
//   seg         : shared cathode bus, active-low
//   an          : anode enables, active-low, an[3] = dig1 ... an[0] = dig4
//   frame_done  : one-cycle pulse in the last cycle of each frame
// master = game-control side, slave = scan controller.
interface seg_scan_if;
    logic       enable;
    logic [6:0] dig1;
    logic [6:0] dig2;
    logic [6:0] dig3;
    logic [6:0] dig4;
    logic [3:0] blink_mask;
    logic [6:0] seg;
    logic [3:0] an;
    logic       frame_done;

    modport master (
        output enable, dig1, dig2, dig3, dig4, blink_mask,
        input  seg, an, frame_done
    );

    modport slave (
        input  enable, dig1, dig2, dig3, dig4, blink_mask,
        output seg, an, frame_done
    );
endinterface

// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: time-multiplexed scan controller for a 4-digit seven-segment
// display. Each digit gets a slot of REFRESH_DIV cycles; the first DEAD_CYCLES
// of a slot are blanked to avoid ghosting. Digit codes, blink mask and blink
// phase are captured once per frame so a frame never mixes old and new values.
// Ports:
//   clk   : system clock
//   RESET : asynchronous, active-high reset
//   bus   : seg_scan_if.slave (inputs enable/dig1..dig4/blink_mask,
//           registered outputs seg/an/frame_done)
module seg_scan_ctrl #(
    parameter int REFRESH_DIV = 100000,
    parameter int DEAD_CYCLES = 1000,
    parameter int BLINK_DIV   = 50000000
) (
    input  logic       clk,
    input  logic       RESET,
    seg_scan_if.slave  bus
);

    localparam int OFF_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int BLK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [OFF_W-1:0] OFF_LAST = OFF_W'(REFRESH_DIV - 1);
    localparam logic [OFF_W-1:0] DEAD_OFF = OFF_W'(DEAD_CYCLES);
    localparam logic [BLK_W-1:0] BLK_LAST = BLK_W'(BLINK_DIV - 1);

    typedef enum logic {
        ST_BLANK = 1'b0,
        ST_DRIVE = 1'b1
    } slot_state_e;

    // The position counter p is kept as {slot, offset} so that p / R and
    // p mod R need no divider.
    logic [1:0]       slot_q, slot_d;
    logic [OFF_W-1:0] offset_q, offset_d;
    logic [BLK_W-1:0] blink_cnt_q, blink_cnt_d;
    logic             blink_ph_q, blink_ph_d;
    logic [6:0]       sh_dig1_q, sh_dig1_d;
    logic [6:0]       sh_dig2_q, sh_dig2_d;
    logic [6:0]       sh_dig3_q, sh_dig3_d;
    logic [6:0]       sh_dig4_q, sh_dig4_d;
    logic [3:0]       sh_mask_q, sh_mask_d;
    logic             sh_ph_q, sh_ph_d;
    logic [6:0]       seg_q, seg_d;
    logic [3:0]       an_q, an_d;
    logic             frame_done_q, frame_done_d;

    slot_state_e      slot_state_s;
    logic             frame_start_s;
    logic             frame_last_s;
    logic [6:0]       sel_dig_s;
    logic [3:0]       sel_an_s;
    logic             sel_mask_s;

    // Next-state logic for counters, shadow registers and output registers.
    always_comb begin
        offset_d     = offset_q;
        slot_d       = slot_q;
        blink_cnt_d  = blink_cnt_q;
        blink_ph_d   = blink_ph_q;
        sh_dig1_d    = sh_dig1_q;
        sh_dig2_d    = sh_dig2_q;
        sh_dig3_d    = sh_dig3_q;
        sh_dig4_d    = sh_dig4_q;
        sh_mask_d    = sh_mask_q;
        sh_ph_d      = sh_ph_q;
        seg_d        = 7'b1111111;
        an_d         = 4'b1111;
        sel_dig_s    = 7'b1111111;
        sel_an_s     = 4'b1111;
        sel_mask_s   = 1'b0;

        frame_start_s = (slot_q == 2'd0) && (offset_q == {OFF_W{1'b0}});
        frame_last_s  = (slot_q == 2'd3) && (offset_q == OFF_LAST);
        frame_done_d  = frame_last_s;

        if (offset_q == OFF_LAST) begin
            offset_d = {OFF_W{1'b0}};
            slot_d   = slot_q + 2'd1;
        end else begin
            offset_d = offset_q + {{(OFF_W-1){1'b0}}, 1'b1};
            slot_d   = slot_q;
        end

        if (blink_cnt_q == BLK_LAST) begin
            blink_cnt_d = {BLK_W{1'b0}};
            blink_ph_d  = ~blink_ph_q;
        end else begin
            blink_cnt_d = blink_cnt_q + {{(BLK_W-1){1'b0}}, 1'b1};
            blink_ph_d  = blink_ph_q;
        end

        // Capture uses the pre-edge phase, so a toggle on the same edge
        // lands in the following frame.
        if (frame_start_s) begin
            sh_dig1_d = bus.dig1;
            sh_dig2_d = bus.dig2;
            sh_dig3_d = bus.dig3;
            sh_dig4_d = bus.dig4;
            sh_mask_d = bus.blink_mask;
            sh_ph_d   = blink_ph_q;
        end else begin
            sh_dig1_d = sh_dig1_q;
            sh_dig2_d = sh_dig2_q;
            sh_dig3_d = sh_dig3_q;
            sh_dig4_d = sh_dig4_q;
            sh_mask_d = sh_mask_q;
            sh_ph_d   = sh_ph_q;
        end

        case (slot_q)
            2'd0: begin sel_dig_s = sh_dig1_q; sel_an_s = 4'b0111; sel_mask_s = sh_mask_q[3]; end
            2'd1: begin sel_dig_s = sh_dig2_q; sel_an_s = 4'b1011; sel_mask_s = sh_mask_q[2]; end
            2'd2: begin sel_dig_s = sh_dig3_q; sel_an_s = 4'b1101; sel_mask_s = sh_mask_q[1]; end
            2'd3: begin sel_dig_s = sh_dig4_q; sel_an_s = 4'b1110; sel_mask_s = sh_mask_q[0]; end
            default: begin sel_dig_s = 7'b1111111; sel_an_s = 4'b1111; sel_mask_s = 1'b0; end
        endcase

        // A blinked-off slot and a disabled display both look like BLANK.
        if ((offset_q >= DEAD_OFF) && !(sh_ph_q && sel_mask_s)) begin
            slot_state_s = ST_DRIVE;
        end else begin
            slot_state_s = ST_BLANK;
        end

        case (slot_state_s)
            ST_DRIVE: begin
                if (bus.enable) begin
                    seg_d = sel_dig_s;
                    an_d  = sel_an_s;
                end else begin
                    seg_d = 7'b1111111;
                    an_d  = 4'b1111;
                end
            end
            ST_BLANK: begin
                seg_d = 7'b1111111;
                an_d  = 4'b1111;
            end
            default: begin
                seg_d = 7'b1111111;
                an_d  = 4'b1111;
            end
        endcase
    end

    // State and output registers with asynchronous reset.
    always_ff @(posedge clk or posedge RESET) begin
        if (RESET) begin
            offset_q     <= {OFF_W{1'b0}};
            slot_q       <= 2'd0;
            blink_cnt_q  <= {BLK_W{1'b0}};
            blink_ph_q   <= 1'b0;
            sh_dig1_q    <= 7'b1111111;
            sh_dig2_q    <= 7'b1111111;
            sh_dig3_q    <= 7'b1111111;
            sh_dig4_q    <= 7'b1111111;
            sh_mask_q    <= 4'b0000;
            sh_ph_q      <= 1'b0;
            seg_q        <= 7'b1111111;
            an_q         <= 4'b1111;
            frame_done_q <= 1'b0;
        end else begin
            offset_q     <= offset_d;
            slot_q       <= slot_d;
            blink_cnt_q  <= blink_cnt_d;
            blink_ph_q   <= blink_ph_d;
            sh_dig1_q    <= sh_dig1_d;
            sh_dig2_q    <= sh_dig2_d;
            sh_dig3_q    <= sh_dig3_d;
            sh_dig4_q    <= sh_dig4_d;
            sh_mask_q    <= sh_mask_d;
            sh_ph_q      <= sh_ph_d;
            seg_q        <= seg_d;
            an_q         <= an_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign bus.seg        = seg_q;
    assign bus.an         = an_q;
    assign bus.frame_done = frame_done_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Testbench for seg_scan_ctrl with R = 8, D = 2, BLINK_DIV = 32.
// A per-edge model predicts the outputs from the edge number and the inputs
// present before each edge; predictions go into a queue and are popped and
// compared one cycle later inside each scenario task.
module tb_seg_scan_ctrl;

    localparam int R     = 8;
    localparam int D     = 2;
    localparam int B     = 32;
    localparam int FRAME = 4 * R;

    typedef struct packed {
        logic [3:0] an;
        logic [6:0] seg;
        logic       fd;
    } exp_t;

    logic clk = 1'b0;
    logic RESET;
    always #5 clk = ~clk;

    seg_scan_if bus();

    seg_scan_ctrl #(
        .REFRESH_DIV(R),
        .DEAD_CYCLES(D),
        .BLINK_DIV  (B)
    ) dut (
        .clk  (clk),
        .RESET(RESET),
        .bus  (bus)
    );

    int   checks   = 0;
    int   failures = 0;
    int   e        = 0;
    int   fd_count = 0;
    exp_t sb[$];
    logic [6:0] m_dig[4];
    logic [3:0] m_mask;
    logic       m_ph;

    // Predict the outputs for the coming edge, then take that edge.
    task automatic step();
        int p;
        int slot;
        int off;
        exp_t x;
        e++;
        p = (e - 1) % FRAME;
        if (p == 0) begin
            m_dig[0] = bus.dig1;
            m_dig[1] = bus.dig2;
            m_dig[2] = bus.dig3;
            m_dig[3] = bus.dig4;
            m_mask   = bus.blink_mask;
            m_ph     = (((e - 1) / B) % 2) == 1;
        end
        slot  = p / R;
        off   = p % R;
        x.fd  = (p == FRAME - 1);
        x.an  = 4'b1111;
        x.seg = 7'b1111111;
        if (bus.enable && off >= D && !(m_ph && m_mask[3 - slot])) begin
            x.an  = ~(4'b0001 << (3 - slot));
            x.seg = m_dig[slot];
        end
        sb.push_back(x);
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        RESET = 1'b1;
        #7;
        @(negedge clk);
        RESET = 1'b0;
        e = 0;
        sb.delete();
    endtask

    task automatic set_digits();
        bus.dig1       = 7'b1000000;
        bus.dig2       = 7'b1111001;
        bus.dig3       = 7'b0100100;
        bus.dig4       = 7'b0110000;
        bus.enable     = 1'b1;
        bus.blink_mask = 4'b0000;
    endtask

    task automatic test_reset();
        exp_t x;
        set_digits();
        RESET = 1'b1;
        #12;
        checks++;
        if ({bus.an, bus.seg, bus.frame_done} !== {4'b1111, 7'b1111111, 1'b0}) begin
            failures++;
            $display("FAIL reset_hold: got an=%b seg=%b fd=%b, want an=1111 seg=1111111 fd=0",
                     bus.an, bus.seg, bus.frame_done);
        end
        @(negedge clk);
        RESET = 1'b0;
        e = 0;
        sb.delete();
        for (int i = 0; i < 5; i++) begin
            step();
            x = sb.pop_front();
            checks++;
            if ({bus.an, bus.seg, bus.frame_done} !== x) begin
                failures++;
                $display("FAIL reset_run e%0d: got %b/%b/%b want %b/%b/%b",
                         e, bus.an, bus.seg, bus.frame_done, x.an, x.seg, x.fd);
            end
        end
        // Mid-DRIVE at edge 5; reset must blank before the next clock edge.
        #2;
        RESET = 1'b1;
        #1;
        checks++;
        if ({bus.an, bus.seg, bus.frame_done} !== {4'b1111, 7'b1111111, 1'b0}) begin
            failures++;
            $display("FAIL reset_async: got an=%b seg=%b fd=%b, want an=1111 seg=1111111 fd=0",
                     bus.an, bus.seg, bus.frame_done);
        end
        apply_reset();
    endtask

    task automatic test_scan();
        exp_t x;
        set_digits();
        apply_reset();
        for (int i = 0; i < FRAME; i++) begin
            step();
            x = sb.pop_front();
            checks++;
            if ({bus.an, bus.seg, bus.frame_done} !== x) begin
                failures++;
                $display("FAIL scan e%0d: got %b/%b/%b want %b/%b/%b",
                         e, bus.an, bus.seg, bus.frame_done, x.an, x.seg, x.fd);
            end
            if (e == 3 || e == 11 || e == 32) begin
                checks++;
                if ((e == 3  && {bus.an, bus.seg} !== {4'b0111, 7'b1000000}) ||
                    (e == 11 && {bus.an, bus.seg} !== {4'b1011, 7'b1111001}) ||
                    (e == 32 && bus.frame_done !== 1'b1)) begin
                    failures++;
                    $display("FAIL scan_fixed e%0d: got an=%b seg=%b fd=%b",
                             e, bus.an, bus.seg, bus.frame_done);
                end
            end
        end
    endtask

    task automatic test_no_tear();
        exp_t x;
        set_digits();
        apply_reset();
        for (int i = 0; i < 40; i++) begin
            if (e == 4) bus.dig1 = 7'b0010010;
            step();
            x = sb.pop_front();
            checks++;
            if ({bus.an, bus.seg, bus.frame_done} !== x) begin
                failures++;
                $display("FAIL no_tear e%0d: got %b/%b/%b want %b/%b/%b",
                         e, bus.an, bus.seg, bus.frame_done, x.an, x.seg, x.fd);
            end
            if (e == 6 || e == 36) begin
                checks++;
                if ((e == 6  && {bus.an, bus.seg} !== {4'b0111, 7'b1000000}) ||
                    (e == 36 && {bus.an, bus.seg} !== {4'b0111, 7'b0010010})) begin
                    failures++;
                    $display("FAIL no_tear_fixed e%0d: got an=%b seg=%b", e, bus.an, bus.seg);
                end
            end
        end
    endtask

    task automatic test_blink();
        exp_t x;
        set_digits();
        bus.blink_mask = 4'b1000;
        apply_reset();
        for (int i = 0; i < 72; i++) begin
            step();
            x = sb.pop_front();
            checks++;
            if ({bus.an, bus.seg, bus.frame_done} !== x) begin
                failures++;
                $display("FAIL blink e%0d: got %b/%b/%b want %b/%b/%b",
                         e, bus.an, bus.seg, bus.frame_done, x.an, x.seg, x.fd);
            end
            if (e == 37 || e == 45 || e == 68) begin
                checks++;
                if ((e == 37 && bus.an !== 4'b1111) ||
                    (e == 45 && {bus.an, bus.seg} !== {4'b1011, 7'b1111001}) ||
                    (e == 68 && {bus.an, bus.seg} !== {4'b0111, 7'b1000000})) begin
                    failures++;
                    $display("FAIL blink_fixed e%0d: got an=%b seg=%b", e, bus.an, bus.seg);
                end
            end
        end
    endtask

    task automatic test_enable();
        exp_t x;
        set_digits();
        apply_reset();
        for (int i = 0; i < 48; i++) begin
            if (e == 12) bus.enable = 1'b0;
            if (e == 44) bus.enable = 1'b1;
            step();
            x = sb.pop_front();
            checks++;
            if ({bus.an, bus.seg, bus.frame_done} !== x) begin
                failures++;
                $display("FAIL enable e%0d: got %b/%b/%b want %b/%b/%b",
                         e, bus.an, bus.seg, bus.frame_done, x.an, x.seg, x.fd);
            end
            if (e == 20 || e == 32 || e == 45) begin
                checks++;
                if ((e == 20 && bus.an !== 4'b1111) ||
                    (e == 32 && {bus.an, bus.frame_done} !== {4'b1111, 1'b1}) ||
                    (e == 45 && {bus.an, bus.seg} !== {4'b1011, 7'b1111001})) begin
                    failures++;
                    $display("FAIL enable_fixed e%0d: got an=%b seg=%b fd=%b",
                             e, bus.an, bus.seg, bus.frame_done);
                end
            end
        end
    endtask

    task automatic test_wrap();
        exp_t x;
        set_digits();
        apply_reset();
        fd_count = 0;
        for (int i = 0; i < 3 * FRAME + 3; i++) begin
            step();
            x = sb.pop_front();
            checks++;
            if ({bus.an, bus.seg, bus.frame_done} !== x) begin
                failures++;
                $display("FAIL wrap e%0d: got %b/%b/%b want %b/%b/%b",
                         e, bus.an, bus.seg, bus.frame_done, x.an, x.seg, x.fd);
            end
            if (bus.frame_done === 1'b1) fd_count++;
            if (e == 33 || e == 35) begin
                checks++;
                if ((e == 33 && bus.an !== 4'b1111) || (e == 35 && bus.an !== 4'b0111)) begin
                    failures++;
                    $display("FAIL wrap_fixed e%0d: got an=%b", e, bus.an);
                end
            end
        end
        checks++;
        if (fd_count !== 3) begin
            failures++;
            $display("FAIL wrap_pulses: got %0d frame_done pulses, want 3", fd_count);
        end
    endtask

    initial begin
        RESET = 1'b1;
        set_digits();
        test_reset();
        test_scan();
        test_no_tear();
        test_blink();
        test_enable();
        test_wrap();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
